// File: rtl/power_up_sequencer.sv
// power_up_sequencer
// Brings N_STAGES downstream enables up in order after reset, one every
// GAP_CYCLES clocks, then supervises the application with a heartbeat
// watchdog. A timeout or a soft restart drains the enables highest-first
// and re-runs the bring-up sequence. All outputs come straight from flops.

module power_up_sequencer #(
   parameter int N_STAGES   = 4,
   parameter int GAP_CYCLES = 256,
   parameter int WDT_CYCLES = 4096
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                heartbeat_i,
   input  logic                soft_restart_i,
   output logic [N_STAGES-1:0] stage_en_o,
   output logic                ready_o,
   output logic                wdt_trip_o,
   output logic [7:0]          trip_count_o
);

   // Counter widths sized to the largest value each counter has to hold
   localparam int GAP_W = $clog2(GAP_CYCLES);
   localparam int WDT_W = $clog2(WDT_CYCLES);
   localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [WDT_W-1:0]    WDT_LAST = WDT_W'(WDT_CYCLES - 1);
   localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_STAGES - 1);
   localparam logic [N_STAGES-1:0] EN_ONE   = N_STAGES'(1);
   localparam logic [GAP_W-1:0]    GAP_INC  = GAP_W'(1);
   localparam logic [WDT_W-1:0]    WDT_INC  = WDT_W'(1);
   localparam logic [IDX_W-1:0]    IDX_INC  = IDX_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEQ   = 2'd1,
      S_RUN   = 2'd2,
      S_DRAIN = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [GAP_W-1:0]    gap_q,   gap_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [WDT_W-1:0]    wdt_q,   wdt_d;
   logic [N_STAGES-1:0] en_q,    en_d;
   logic                ready_q, ready_d;
   logic                trip_q,  trip_d;
   logic [7:0]          tcnt_q,  tcnt_d;

   // Decoded per-cycle events shared by the next-state and datapath logic
   logic gap_last;
   logic idx_last;
   logic seq_done;
   logic timeout;
   logic drain_done;

   // Event decode
   always_comb begin
      gap_last   = (gap_q == GAP_LAST);
      idx_last   = (idx_q == IDX_LAST);
      // A soft restart on the final gap tick wins: the last stage is not set
      seq_done   = (state_q == S_SEQ) && gap_last && idx_last && !soft_restart_i;
      // A heartbeat on the timeout edge rescues the application
      timeout    = (state_q == S_RUN) && (wdt_q == WDT_LAST) && !heartbeat_i;
      // Thermometer code: shifting right clears the highest set bit, so the
      // drain finishes on the edge where at most bit 0 is still set
      drain_done = (state_q == S_DRAIN) && ((en_q >> 1) == '0);
   end

   // State register and all datapath/output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         gap_q   <= '0;
         idx_q   <= '0;
         wdt_q   <= '0;
         en_q    <= '0;
         ready_q <= 1'b0;
         trip_q  <= 1'b0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         gap_q   <= gap_d;
         idx_q   <= idx_d;
         wdt_q   <= wdt_d;
         en_q    <= en_d;
         ready_q <= ready_d;
         trip_q  <= trip_d;
         tcnt_q  <= tcnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_SEQ;
         end
         S_SEQ: begin
            if (soft_restart_i) begin
               state_d = S_DRAIN;
            end else if (seq_done) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // Timeout and soft restart both drain; only the timeout trips
            if (timeout || soft_restart_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_done) begin
               state_d = S_SEQ;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Next values of counters and registered outputs
   always_comb begin
      gap_d   = gap_q;
      idx_d   = idx_q;
      wdt_d   = wdt_q;
      en_d    = en_q;
      ready_d = ready_q;
      trip_d  = 1'b0;
      tcnt_d  = tcnt_q;
      unique case (state_q)
         S_IDLE: begin
            gap_d   = '0;
            idx_d   = '0;
            en_d    = '0;
            ready_d = 1'b0;
         end
         S_SEQ: begin
            if (soft_restart_i) begin
               ready_d = 1'b0;
            end else if (gap_last) begin
               gap_d = '0;
               en_d  = en_q | (EN_ONE << idx_q);
               if (idx_last) begin
                  idx_d   = '0;
                  ready_d = 1'b1;
                  wdt_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_INC;
               end
            end else begin
               gap_d = gap_q + GAP_INC;
            end
         end
         S_RUN: begin
            if (timeout) begin
               trip_d  = 1'b1;
               ready_d = 1'b0;
               wdt_d   = '0;
               if (tcnt_q != 8'hFF) begin
                  tcnt_d = tcnt_q + 8'd1;
               end
            end else begin
               if (heartbeat_i) begin
                  wdt_d = '0;
               end else begin
                  wdt_d = wdt_q + WDT_INC;
               end
               if (soft_restart_i) begin
                  ready_d = 1'b0;
               end
            end
         end
         S_DRAIN: begin
            en_d = en_q >> 1;
            if (drain_done) begin
               gap_d = '0;
               idx_d = '0;
            end
         end
         default: begin
            gap_d   = '0;
            idx_d   = '0;
            en_d    = '0;
            ready_d = 1'b0;
         end
      endcase
   end

   assign stage_en_o   = en_q;
   assign ready_o      = ready_q;
   assign wdt_trip_o   = trip_q;
   assign trip_count_o = tcnt_q;

   // Enables never have gaps (x & (x+1) is zero only for 0..01..1)
   a_thermo: assert property (@(posedge clk_i) disable iff (rst_i)
      ((en_q & (en_q + EN_ONE)) == '0));

   // Ready implies every stage is enabled
   a_ready_full: assert property (@(posedge clk_i) disable iff (rst_i)
      (ready_q |-> (&en_q)));

   // The trip pulse is exactly one cycle wide
   a_trip_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
      (trip_q |=> !trip_q));

endmodule
